router_reg_param: RTL and testbench

- Parametrised successor of the router 1x3 datapath register block; sits between the router FSM and the destination FIFOs.
- Latches the header, holds the byte that arrives while a FIFO is full, and drives the FIFO write data.
- Computes packet integrity in XOR or additive-checksum mode, counts payload bytes against the header length field, and flags parity and length errors, with optional sticky error reporting.

---
 rtl/router_reg_param.sv | 153 +++++++++++++++
 tb/tb_router_reg_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg_param.sv
// router_reg_param: datapath register block between the router FSM and the
// destination FIFOs. It latches the header, parks the byte that arrives while
// a FIFO is full, drives FIFO write data, and checks packet integrity. The
// integrity check is XOR parity or an additive checksum. It also checks the
// payload length against the header.
module router_reg_param #(
  parameter int DW          = 8,
  parameter int ADDR_W      = 2,
  parameter int PARITY_MODE = 0,
  parameter int CHK_LEN     = 1,
  parameter int STICKY_ERR  = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [DW-1:0]        data_in,
  input  logic                 fifo_full,
  input  logic                 rst_int_reg,
  input  logic                 detect_add,
  input  logic                 ld_state,
  input  logic                 laf_state,
  input  logic                 full_state,
  input  logic                 lfd_state,
  output logic                 parity_done,
  output logic                 low_pkt_valid,
  output logic                 err,
  output logic                 len_err,
  output logic [DW-1:0]        dout,
  output logic [DW-ADDR_W-1:0] byte_cnt
);

  localparam int            LW      = DW - ADDR_W;
  localparam logic [LW-1:0] CNT_MAX = '1;
  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  logic [DW-1:0] r_header;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_dout;
  logic [DW-1:0] r_chk;
  logic [DW-1:0] r_pkt_par;
  logic [LW-1:0] r_byte_cnt;
  logic          r_parity_done;
  logic          r_low_pkt_valid;
  logic          r_err;
  logic          r_len_err;

  logic          w_acc;
  logic          w_par_load;
  logic          w_err_next;
  logic          w_len_next;
  logic [DW-1:0] w_chk_next;

  // Integrity combine step: XOR parity or a checksum truncated to DW bits.
  function automatic logic [DW-1:0] chk_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (PARITY_MODE == 1) return a + b;
    else                  return a ^ b;
  endfunction

  // The byte parked while the FIFO is full is counted when it arrives.
  assign w_acc      = ld_state & pkt_valid & ~full_state;
  assign w_par_load = (ld_state & ~pkt_valid & ~fifo_full) |
                      (laf_state & r_low_pkt_valid & ~r_parity_done);
  assign w_err_next = r_parity_done & (r_chk != r_pkt_par);
  assign w_len_next = (CHK_LEN != 0) && r_parity_done &&
                      (r_byte_cnt != r_header[DW-1:ADDR_W]);

  // Next value of the running integrity accumulator.
  always_comb begin
    // NOTE: default first so every path assigns w_chk_next; otherwise a latch is inferred.
    w_chk_next = r_chk;
    if (detect_add)                    w_chk_next = '0;
    else if (lfd_state)                w_chk_next = chk_f(r_chk, r_header);
    else if (w_acc)                    w_chk_next = chk_f(r_chk, data_in);
    else if (~pkt_valid & rst_int_reg) w_chk_next = '0;
  end

  // Capture the header during address decode and the byte that meets a full FIFO.
  // NOTE: every register, including data holders, is cleared by the async reset so no stale packet survives it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_header <= '0;
      r_hold   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
      if (pkt_valid & detect_add)  r_header <= data_in;
      if (ld_state & fifo_full)    r_hold   <= data_in;
    end
  end

  // FIFO write data: header first, then live bytes, then the parked byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       r_dout <= '0;
    else if (lfd_state)                r_dout <= r_header;
    else if (ld_state & ~fifo_full)    r_dout <= data_in;
    else if (laf_state)                r_dout <= r_hold;
  end

  // Running integrity value and the packet's own parity byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_chk     <= '0;
      r_pkt_par <= '0;
    end else begin
      r_chk <= w_chk_next;
      if (w_par_load)                    r_pkt_par <= data_in;
      else if (~pkt_valid & rst_int_reg) r_pkt_par <= '0;
      else if (detect_add)               r_pkt_par <= '0;
    end
  end

  // Payload byte counter; saturates so an over-long packet never wraps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              r_byte_cnt <= '0;
    else if (detect_add)                      r_byte_cnt <= '0;
    else if (w_acc && r_byte_cnt != CNT_MAX)  r_byte_cnt <= r_byte_cnt + CNT_ONE;
  end

  // Packet-end flags: parity byte seen, and source dropped pkt_valid mid-load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_parity_done   <= 1'b0;
      r_low_pkt_valid <= 1'b0;
    end else begin
      if (w_par_load)      r_parity_done <= 1'b1;
      else if (detect_add) r_parity_done <= 1'b0;

      if (ld_state & ~pkt_valid) r_low_pkt_valid <= 1'b1;
      else if (rst_int_reg)      r_low_pkt_valid <= 1'b0;
    end
  end

  // Error flags, either live or held until the next address decode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err     <= 1'b0;
      r_len_err <= 1'b0;
    end else if (STICKY_ERR != 0) begin
      r_err     <= (r_err     | w_err_next) & ~detect_add;
      r_len_err <= (r_len_err | w_len_next) & ~detect_add;
    end else begin
      r_err     <= w_err_next;
      r_len_err <= w_len_next;
    end
  end

  assign dout          = r_dout;
  assign byte_cnt      = r_byte_cnt;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_router_reg_param.sv
// Directed bench for router_reg_param. The main instance uses the default
// parameters (XOR, live errors). A second instance uses checksum mode with
// sticky errors. Both instances share all inputs.
module tb_router_reg_param;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, rst_int_reg, detect_add;
  logic       ld_state, laf_state, full_state, lfd_state;
  logic [7:0] data_in;

  logic       parity_done, low_pkt_valid, err, len_err;
  logic [7:0] dout;
  logic [5:0] byte_cnt;

  logic       s_parity_done, s_low_pkt_valid, s_err, s_len_err;
  logic [7:0] s_dout;
  logic [5:0] s_byte_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_reg_param u_dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .lfd_state(lfd_state), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .err(err), .len_err(len_err), .dout(dout), .byte_cnt(byte_cnt)
  );

  router_reg_param #(.PARITY_MODE(1), .STICKY_ERR(1)) u_dut_sum (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .lfd_state(lfd_state), .parity_done(s_parity_done), .low_pkt_valid(s_low_pkt_valid),
    .err(s_err), .len_err(s_len_err), .dout(s_dout), .byte_cnt(s_byte_cnt)
  );

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic pv, input logic [7:0] din, input logic full,
                      input logic rsti, input logic det, input logic ld,
                      input logic laf, input logic fs, input logic lfd);
    pkt_valid = pv; data_in = din; fifo_full = full; rst_int_reg = rsti;
    detect_add = det; ld_state = ld; laf_state = laf; full_state = fs; lfd_state = lfd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();             step(1'b0, 8'h00, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic hdr(input logic [7:0] h); step(1'b1, h,     0, 0, 1, 0, 0, 0, 0); endtask
  task automatic lfd();              step(1'b1, 8'h00, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic ld(input logic [7:0] b);  step(1'b1, b,     0, 0, 0, 1, 0, 0, 0); endtask
  task automatic par(input logic [7:0] p); step(1'b0, p,     0, 0, 0, 1, 0, 0, 0); endtask

  task automatic send_pkt(input logic [7:0] h, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] p);
    hdr(h); lfd(); ld(b0); ld(b1); ld(b2); par(p);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    pkt_valid = 0; data_in = 8'h00; fifo_full = 0; rst_int_reg = 0; detect_add = 0;
    ld_state = 0; laf_state = 0; full_state = 0; lfd_state = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout !== 8'h00)        begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (byte_cnt !== 6'd0)     begin errors++; $display("FAIL reset_byte_cnt got %0d exp 0", byte_cnt); end
    checks++; if (parity_done !== 1'b0)  begin errors++; $display("FAIL reset_parity_done got %b exp 0", parity_done); end
    checks++; if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_low_pkt got %b exp 0", low_pkt_valid); end
    checks++; if (err !== 1'b0)          begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (len_err !== 1'b0)      begin errors++; $display("FAIL reset_len_err got %b exp 0", len_err); end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Header 0x0D: addr 1, len 3; XOR parity of 0D,11,22,33 is 0D.
  task automatic test_basic();
    hdr(8'h0D);
    checks++; if (byte_cnt !== 6'd0)    begin errors++; $display("FAIL basic_cnt_clr got %0d exp 0", byte_cnt); end
    lfd();
    checks++; if (dout !== 8'h0D)       begin errors++; $display("FAIL basic_dout_hdr got %h exp 0d", dout); end
    ld(8'h11);
    checks++; if (dout !== 8'h11)       begin errors++; $display("FAIL basic_dout_b0 got %h exp 11", dout); end
    ld(8'h22);
    checks++; if (dout !== 8'h22)       begin errors++; $display("FAIL basic_dout_b1 got %h exp 22", dout); end
    ld(8'h33);
    checks++; if (dout !== 8'h33)       begin errors++; $display("FAIL basic_dout_b2 got %h exp 33", dout); end
    checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL basic_pd_early got %b exp 0", parity_done); end
    par(8'h0D);
    checks++; if (parity_done !== 1'b1) begin errors++; $display("FAIL basic_pd got %b exp 1", parity_done); end
    checks++; if (low_pkt_valid !== 1'b1) begin errors++; $display("FAIL basic_low_pkt got %b exp 1", low_pkt_valid); end
    idle();
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL basic_err got %b exp 0", err); end
    checks++; if (len_err !== 1'b0)     begin errors++; $display("FAIL basic_len_err got %b exp 0", len_err); end
    checks++; if (byte_cnt !== 6'd3)    begin errors++; $display("FAIL basic_cnt got %0d exp 3", byte_cnt); end
  endtask

  // Wrong parity 0x0C: live err holds until detect_add clears parity_done.
  task automatic test_err_live();
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C);
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL errlive_same_cycle got %b exp 0", err); end
    idle();
    checks++; if (err !== 1'b1)   begin errors++; $display("FAIL errlive_set got %b exp 1", err); end
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL errlive_sum_set got %b exp 1", s_err); end
    idle();
    checks++; if (err !== 1'b1)   begin errors++; $display("FAIL errlive_hold got %b exp 1", err); end
    hdr(8'h0D);
    checks++; if (err !== 1'b1)   begin errors++; $display("FAIL errlive_at_det got %b exp 1", err); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL errsticky_clr_at_det got %b exp 0", s_err); end
    lfd();
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL errlive_drop got %b exp 0", err); end
  endtask

  // Checksum mode: 0D+11+22+33 = 73. Sticky err survives rst_int_reg.
  task automatic test_checksum_sticky();
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h73);
    idle();
    checks++; if (s_err !== 1'b0)     begin errors++; $display("FAIL sum_good_err got %b exp 0", s_err); end
    checks++; if (s_len_err !== 1'b0) begin errors++; $display("FAIL sum_good_len got %b exp 0", s_len_err); end
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h72);
    idle();
    checks++; if (s_err !== 1'b1)     begin errors++; $display("FAIL sum_bad_err got %b exp 1", s_err); end
    step(1'b0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
    idle();
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL live_after_rstint got %b exp 0", err); end
    checks++; if (s_err !== 1'b1)     begin errors++; $display("FAIL sticky_after_rstint got %b exp 1", s_err); end
    hdr(8'h0D);
    checks++; if (s_err !== 1'b0)     begin errors++; $display("FAIL sticky_clear got %b exp 0", s_err); end
  endtask

  // Header 0x11 claims 4 bytes, only 3 sent; XOR parity 11^11^22^33 = 11.
  task automatic test_len();
    send_pkt(8'h11, 8'h11, 8'h22, 8'h33, 8'h11);
    idle();
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL len_err_parity got %b exp 0", err); end
    checks++; if (len_err !== 1'b1)  begin errors++; $display("FAIL len_mismatch got %b exp 1", len_err); end
    checks++; if (byte_cnt !== 6'd3) begin errors++; $display("FAIL len_cnt got %0d exp 3", byte_cnt); end
  endtask

  // Header 0x09 (len 2); 0x5A meets a full FIFO and is replayed in laf_state.
  // Parity 09^11^5A = 42.
  task automatic test_hold_full();
    hdr(8'h09); lfd(); ld(8'h11);
    step(1'b1, 8'h5A, 1, 0, 0, 1, 0, 0, 0);
    checks++; if (dout !== 8'h11)    begin errors++; $display("FAIL hold_dout_stall got %h exp 11", dout); end
    step(1'b1, 8'hEE, 1, 0, 0, 0, 0, 1, 0);
    step(1'b1, 8'hEE, 0, 0, 0, 0, 1, 0, 0);
    checks++; if (dout !== 8'h5A)    begin errors++; $display("FAIL hold_dout_laf got %h exp 5a", dout); end
    par(8'h42);
    checks++; if (dout !== 8'h42)    begin errors++; $display("FAIL hold_dout_par got %h exp 42", dout); end
    idle();
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL hold_err got %b exp 0", err); end
    checks++; if (len_err !== 1'b0)  begin errors++; $display("FAIL hold_len_err got %b exp 0", len_err); end
    checks++; if (byte_cnt !== 6'd2) begin errors++; $display("FAIL hold_cnt got %0d exp 2", byte_cnt); end
  endtask

  // Header 0x05 (len 1); pkt_valid falls while full. Parity 05^11 = 14 is taken in laf_state.
  task automatic test_laf_parity();
    hdr(8'h05); lfd(); ld(8'h11);
    step(1'b0, 8'h14, 1, 0, 0, 1, 0, 0, 0);
    checks++; if (low_pkt_valid !== 1'b1) begin errors++; $display("FAIL laf_low_pkt got %b exp 1", low_pkt_valid); end
    checks++; if (parity_done !== 1'b0)   begin errors++; $display("FAIL laf_pd_early got %b exp 0", parity_done); end
    step(1'b0, 8'h14, 1, 0, 0, 0, 0, 1, 0);
    step(1'b0, 8'h14, 0, 0, 0, 0, 1, 0, 0);
    checks++; if (dout !== 8'h14)         begin errors++; $display("FAIL laf_dout got %h exp 14", dout); end
    checks++; if (parity_done !== 1'b1)   begin errors++; $display("FAIL laf_pd got %b exp 1", parity_done); end
    idle();
    checks++; if (err !== 1'b0)           begin errors++; $display("FAIL laf_err got %b exp 0", err); end
    checks++; if (len_err !== 1'b0)       begin errors++; $display("FAIL laf_len_err got %b exp 0", len_err); end
  endtask

  // rst_int_reg clears low_pkt_valid unless ld_state & ~pkt_valid sets it in the same cycle.
  task automatic test_low_collision();
    step(1'b0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
    checks++; if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL low_clear got %b exp 0", low_pkt_valid); end
    step(1'b0, 8'h00, 0, 1, 0, 1, 0, 0, 0);
    checks++; if (low_pkt_valid !== 1'b1) begin errors++; $display("FAIL low_set_wins got %b exp 1", low_pkt_valid); end
  endtask

  // Reset pulse between clock edges mid-payload, then a clean packet.
  task automatic test_async_reset();
    hdr(8'h0D); lfd(); ld(8'h11); ld(8'h22);
    #3 resetn = 1'b0;
    #1;
    checks++; if (dout !== 8'h00)         begin errors++; $display("FAIL areset_dout got %h exp 00", dout); end
    checks++; if (byte_cnt !== 6'd0)      begin errors++; $display("FAIL areset_cnt got %0d exp 0", byte_cnt); end
    checks++; if (parity_done !== 1'b0)   begin errors++; $display("FAIL areset_pd got %b exp 0", parity_done); end
    checks++; if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL areset_low got %b exp 0", low_pkt_valid); end
    checks++; if (err !== 1'b0)           begin errors++; $display("FAIL areset_err got %b exp 0", err); end
    checks++; if (len_err !== 1'b0)       begin errors++; $display("FAIL areset_len got %b exp 0", len_err); end
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    idle();
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL post_reset_err got %b exp 0", err); end
    checks++; if (len_err !== 1'b0)  begin errors++; $display("FAIL post_reset_len got %b exp 0", len_err); end
    checks++; if (byte_cnt !== 6'd3) begin errors++; $display("FAIL post_reset_cnt got %0d exp 3", byte_cnt); end
  endtask

  // Header 0xFF: length field 63 (max). 70 payload bytes saturate the counter at 63.
  task automatic test_saturation();
    logic [7:0] p;
    p = 8'hFF;
    hdr(8'hFF); lfd();
    for (int i = 1; i <= 70; i++) begin
      ld(8'(i));
      p = p ^ 8'(i);
    end
    par(p);
    idle();
    checks++; if (byte_cnt !== 6'd63) begin errors++; $display("FAIL sat_cnt got %0d exp 63", byte_cnt); end
    checks++; if (len_err !== 1'b0)   begin errors++; $display("FAIL sat_len_err got %b exp 0", len_err); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL sat_err got %b exp 0", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err_live();
    test_checksum_sticky();
    test_len();
    test_hold_full();
    test_laf_parity();
    test_low_collision();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
